uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//  8N1 UART transmitter with a small byte FIFO; the serial stage upstream of the Receiver.
//  Its TX output drives the Receiver's RX line, in loopback or over the wire.
//  Host logic pushes bytes; the block serialises them LSB-first at BAUD.
//  Frames are sent back-to-back while the FIFO is non-empty.
// PARAMETERS
//  CLK_FREQ    12000000  system clock, Hz
//  BAUD        9600      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (1250 at defaults), integer divide
//  FIFO_DEPTH  4         byte FIFO entries; power of two, >= 2
// PORTS
//  CLK     in   1  system clock, rising edge
//  RST     in   1  synchronous, active-low reset (RST=0 resets on the CLK edge)
//  DATA_T  in   8  byte to transmit
//  WR_EN   in   1  push DATA_T; accepted when WR_EN=1 && FULL=0
//  FULL    out  1  FIFO holds FIFO_DEPTH bytes
//  EMPTY   out  1  FIFO holds 0 bytes
//  BUSY    out  1  frame in progress (state != IDLE)
//  TX      out  1  serial line, idles high
// BEHAVIOUR
//  Reset (RST=0 at an edge): TX=1, BUSY=0, FULL=0, EMPTY=1.
//  - Clears the FIFO pointers and count, the baud counter and the bit index; state=IDLE.
//  - Applies mid-frame too: the line returns high on the next edge and queued bytes are lost.
//  FIFO, circular buffer:
//  - Write pointer and read pointer wrap modulo FIFO_DEPTH.
//  - Count width is log2(FIFO_DEPTH)+1.
//  - FULL and EMPTY are registered and decoded from the count.
//  - A write while FULL=1 is dropped silently, even if a pop happens on the same edge.
//  - A simultaneous accepted write and pop leaves the count unchanged.
//  FSM states: IDLE, START, DATA, STOP. Baud counter bcnt runs 0..CLKS_PER_BIT-1.
//  - IDLE: TX=1. If EMPTY=0: pop the head byte into shift reg, go to START, TX=0, bcnt=0.
//  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0 and TX=shift[0].
//  - DATA: each bit is held CLKS_PER_BIT cycles; shift right.
//    After bit 7 completes, go to STOP with TX=1.
//  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end, if EMPTY=0, pop and go straight to START.
//    Otherwise go to IDLE.
//  Timing:
//  - Frame length is exactly 10*CLKS_PER_BIT cycles.
//  - Back-to-back frames have no idle gap.
//  - TX is registered and glitch-free.
//  - Latency: a write accepted at edge n into an empty idle block gives TX falling at edge n+2.
//  - The byte is popped on the same edge that starts its start bit.
//  BUSY is 1 from the start-bit edge until the edge returning to IDLE.
//  DATA_T is sampled only on the accepted-write edge; later changes do not affect queued bytes.
// TESTING
//  1. Reset: hold RST=0 for 4 cycles -> TX=1, BUSY=0, EMPTY=1, FULL=0; TX stays 1 for 20000 cycles.
//  2. Single byte: write 0x33 -> TX falls 2 cycles later.
//     Line sequence 0,1,1,0,0,1,1,0,0,1, each bit 1250 cycles (104.17 us at 12 MHz).
//     BUSY drops after 12500 cycles.
//  3. Back-to-back: write 0x33 then 0x77 on consecutive cycles.
//     The second start bit begins exactly 12500 cycles after the first; no idle gap.
//     The 0x77 data bits are 1,1,1,0,1,1,1,0.
//  4. Overflow: write 6 bytes 0x01..0x06 on consecutive cycles while idle.
//     0x01 is popped immediately; 0x02..0x05 fill the FIFO, so FULL=1 and 0x06 is dropped.
//     Exactly five frames are sent: 0x01 to 0x05.
//  5. Reset mid-frame: assert RST=0 during data bit 3 of 0xA5 with 2 bytes queued.
//     TX=1 on the next edge, EMPTY=1; after release no further frames are sent.
//  6. Loopback into Receiver at 9600 baud: send 0x33 then 0x77 -> DATA_R shows 0x33, then 0x77.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter fed by a small circular byte FIFO.
// Bytes pushed by the host are sent LSB-first, one start bit and one stop bit,
// back-to-back for as long as the FIFO holds data.
module uart_transmitter #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_T,
  input  logic       WR_EN,
  output logic       FULL,
  output logic       EMPTY,
  output logic       BUSY,
  output logic       TX
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BCNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [BCNT_W-1:0] BCNT_ZERO = '0;
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             wr_acc_s;
  logic             pop_s;

  // Serialiser state
  state_t           state_r;
  state_t           state_nxt_s;
  logic [BCNT_W-1:0] bcnt_r;
  logic [BCNT_W-1:0] bcnt_nxt_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic             tx_r;
  logic             tx_nxt_s;
  logic             busy_r;

  // A write is taken only when the registered FULL flag is low; a pop on the
  // same edge does not rescue a write that arrives while full.
  assign wr_acc_s = WR_EN & ~full_r;

  // Next occupancy from the push/pop pair; push+pop leaves the count as is.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Byte storage: DATA_T is captured only on the accepted-write edge.
  always_ff @(posedge CLK) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= DATA_T;
    end
  end

  // FIFO pointers, count and status flags. FULL looks ahead at the next count
  // so consecutive writes can never overrun; EMPTY is decoded from the settled
  // count, giving a fresh byte one cycle in the buffer before it is popped.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_r == CNT_ZERO);
    end
  end

  // Frame sequencer: next state, baud counter, bit index, shifter and line.
  always_comb begin
    state_nxt_s   = state_r;
    bcnt_nxt_s    = bcnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    tx_nxt_s      = tx_r;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_nxt_s   = 1'b1;
        bcnt_nxt_s = BCNT_ZERO;
        if (!empty_r) begin
          pop_s       = 1'b1;
          shift_nxt_s = mem_r[rd_ptr_r];
          state_nxt_s = ST_START;
          tx_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bcnt_r == BCNT_LAST) begin
          bcnt_nxt_s    = BCNT_ZERO;
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = ST_DATA;
          tx_nxt_s      = shift_r[0];
        end else begin
          bcnt_nxt_s = bcnt_r + BCNT_ONE;
        end
      end
      ST_DATA: begin
        if (bcnt_r == BCNT_LAST) begin
          bcnt_nxt_s = BCNT_ZERO;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
            tx_nxt_s    = 1'b1;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
            shift_nxt_s   = {1'b0, shift_r[7:1]};
            tx_nxt_s      = shift_r[1];
          end
        end else begin
          bcnt_nxt_s = bcnt_r + BCNT_ONE;
        end
      end
      ST_STOP: begin
        if (bcnt_r == BCNT_LAST) begin
          bcnt_nxt_s = BCNT_ZERO;
          if (!empty_r) begin
            // Chain straight into the next start bit: no idle gap.
            pop_s       = 1'b1;
            shift_nxt_s = mem_r[rd_ptr_r];
            state_nxt_s = ST_START;
            tx_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
            tx_nxt_s    = 1'b1;
          end
        end else begin
          bcnt_nxt_s = bcnt_r + BCNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        bcnt_nxt_s  = BCNT_ZERO;
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

  // Sequencer registers; TX and BUSY come straight from flops so the line
  // cannot glitch.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      bcnt_r    <= BCNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bcnt_r    <= bcnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign TX    = tx_r;
  assign BUSY  = busy_r;
  assign FULL  = full_r;
  assign EMPTY = empty_r;

endmodule
